// File: rtl/sink_scheduler_pkg.sv
// Shared interconnect definitions: scheduler state encoding and the
// helper that derives an index width from a sink count.
package interconnect_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_SETUP  = 3'd1,
      ST_RD_ACCESS = 3'd2,
      ST_WR_SETUP  = 3'd3,
      ST_WR_ACCESS = 3'd4
   } sched_state_t;

   localparam int unsigned SCHED_NSINKS = 8;

   // A single-entry range still needs one bit to carry an index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sink_scheduler_if.sv
// Sink-valid and APB-side signal bundle between the sink scheduler
// and the interconnect valid logic / APB slave.
interface sink_scheduler_if
   import interconnect_pkg::*;
#(
   parameter int unsigned NSINKS     = SCHED_NSINKS,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned IDX_W = idx_width(NSINKS);

   logic [NSINKS-1:0]     valids_active;
   logic [IDX_W-1:0]      current_idx;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  busy;
   logic                  xfer_done;
   logic                  err;

   modport master (
      input  valids_active, prdata, pready,
      output current_idx, psel, penable, pwrite, paddr, pwdata,
             busy, xfer_done, err
   );

   modport slave (
      output valids_active, prdata, pready,
      input  current_idx, psel, penable, pwrite, paddr, pwdata,
             busy, xfer_done, err
   );

endinterface

// File: rtl/sink_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after
// last_idx+1, wrapping from N-1 back to 0.
module rr_arbiter
   import interconnect_pkg::*;
#(
   parameter  int unsigned N     = SCHED_NSINKS,
   localparam int unsigned IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_idx,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] w_pos;

   // Walk candidates farthest-first so the nearest requester overwrites the rest.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = {IDX_W{1'b0}};
      w_pos       = {IDX_W{1'b0}};
      for (int k = int'(N); k >= 1; k--) begin
         w_pos       = IDX_W'((int'(last_idx) + k) % int'(N));
         grant_idx   = req[w_pos] ? w_pos : grant_idx;
         grant_valid = grant_valid | req[w_pos];
      end
   end

endmodule

// File: rtl/sink_scheduler.sv
// Round-robin sink scheduler: per grant, APB-reads the sink data register
// and writes it to the sink slot. Optional access timeout: SCHED_TIMEOUT_EN.
module sink_scheduler
   import interconnect_pkg::*;
#(
   parameter int unsigned           NSINKS     = SCHED_NSINKS,
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] SINK_BASE  = 8'h80,
   parameter int unsigned           TIMEOUT    = 16
) (
   input  logic             pclk,
   input  logic             rst,
   sink_scheduler_if.master bus
);

   localparam int unsigned      IDX_W    = idx_width(NSINKS);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NSINKS - 1);

   sched_state_t          r_state;
   sched_state_t          w_nxt_state;
   logic [IDX_W-1:0]      r_cur_idx, w_nxt_cur;
   logic [IDX_W-1:0]      r_last_idx, w_nxt_last;
   logic [ADDR_WIDTH-1:0] r_paddr, w_nxt_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata, w_nxt_pwdata;
   logic                  r_pwrite, w_nxt_pwrite;
   logic                  r_psel, r_penable, r_busy, r_xfer_done;
   logic                  w_nxt_done;
   logic                  w_tmo_expired;
   logic                  w_tmo_hit;
   logic                  w_grant_valid;
   logic [IDX_W-1:0]      w_grant_idx;

   rr_arbiter #(.N(NSINKS)) u_arb (
      .req         (bus.valids_active),
      .last_idx    (r_last_idx),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   // Next-state and next-bus-value decode for the read-then-write service pass.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cur    = r_cur_idx;
      w_nxt_last   = r_last_idx;
      w_nxt_paddr  = r_paddr;
      w_nxt_pwrite = r_pwrite;
      w_nxt_pwdata = r_pwdata;
      w_nxt_done   = 1'b0;
      w_tmo_hit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_nxt_state  = ST_RD_SETUP;
               w_nxt_cur    = w_grant_idx;
               w_nxt_last   = w_grant_idx;
               w_nxt_paddr  = SINK_BASE + ADDR_WIDTH'(w_grant_idx);
               w_nxt_pwrite = 1'b0;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_RD_SETUP: w_nxt_state = ST_RD_ACCESS;
         ST_RD_ACCESS: begin
            if (bus.pready) begin
               w_nxt_state  = ST_WR_SETUP;
               w_nxt_pwdata = bus.prdata;
               w_nxt_paddr  = ADDR_WIDTH'(r_cur_idx);
               w_nxt_pwrite = 1'b1;
            end else if (w_tmo_expired) begin
               w_nxt_state = ST_IDLE;
               w_tmo_hit   = 1'b1;
            end else begin
               w_nxt_state = ST_RD_ACCESS;
            end
         end
         ST_WR_SETUP: w_nxt_state = ST_WR_ACCESS;
         ST_WR_ACCESS: begin
            if (bus.pready) begin
               w_nxt_state = ST_IDLE;
               w_nxt_done  = 1'b1;
            end else if (w_tmo_expired) begin
               w_nxt_state = ST_IDLE;
               w_tmo_hit   = 1'b1;
            end else begin
               w_nxt_state = ST_WR_ACCESS;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   // State and registered bus outputs; strobes decode from the next state.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur_idx   <= {IDX_W{1'b0}};
         r_last_idx  <= LAST_RST;
         r_paddr     <= {ADDR_WIDTH{1'b0}};
         r_pwdata    <= {DATA_WIDTH{1'b0}};
         r_pwrite    <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_busy      <= 1'b0;
         r_xfer_done <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_cur_idx   <= w_nxt_cur;
         r_last_idx  <= w_nxt_last;
         r_paddr     <= w_nxt_paddr;
         r_pwdata    <= w_nxt_pwdata;
         r_pwrite    <= w_nxt_pwrite;
         r_psel      <= (w_nxt_state != ST_IDLE);
         r_penable   <= (w_nxt_state == ST_RD_ACCESS) || (w_nxt_state == ST_WR_ACCESS);
         r_busy      <= (w_nxt_state != ST_IDLE);
         r_xfer_done <= w_nxt_done;
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned TMO_W = idx_width(TIMEOUT);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   assign w_tmo_expired = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

   // Access-phase wait counter; any state change restarts it from zero.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end else if (((r_state == ST_RD_ACCESS) || (r_state == ST_WR_ACCESS)) &&
                   (w_nxt_state == r_state)) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1'b1);
      end else begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end
   end

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_tmo_hit) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   assign bus.err = r_err;
`else
   logic w_unused_cfg;

   assign w_tmo_expired = 1'b0;
   assign w_unused_cfg  = ^{TIMEOUT, w_tmo_hit};
   assign bus.err       = 1'b0;
`endif

   assign bus.current_idx = r_cur_idx;
   assign bus.psel        = r_psel;
   assign bus.penable     = r_penable;
   assign bus.pwrite      = r_pwrite;
   assign bus.paddr       = r_paddr;
   assign bus.pwdata      = r_pwdata;
   assign bus.busy        = r_busy;
   assign bus.xfer_done   = r_xfer_done;

endmodule
